// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// No logic, no latency: declarations only.
// No flow control: consumers import what they need.
package seg_disp_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        HOLD = 2'd2
    } arb_state_t;

    // Digit codes understood by seven_seg
    localparam logic [3:0] BLANK_DIGIT = 4'hB;
    localparam logic [3:0] ERR_DIGIT   = 4'hE;

    // Word shown when no client owns the display: four blank digits
    localparam logic [15:0] DEF_IDLE_CODE = {4{BLANK_DIGIT}};

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after ptr, scanning upward with wrap.
// Purely combinational, zero latency.
// No backpressure; found is low when req is all-zero (winner then reads 0).
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     found
);

    localparam int IW = $clog2(N_REQ);
    // One spare bit so ptr + offset cannot overflow before the modulo step
    localparam int SW = IW + 1;

    logic [SW-1:0] sum;
    logic [IW-1:0] idx;

    // Scan from the farthest offset down to the nearest so the nearest hit wins
    always_comb begin
        winner = '0;
        found  = |req;
        sum    = '0;
        idx    = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            sum = SW'(ptr) + SW'(i);
            if (sum >= SW'(N_REQ)) begin
                sum = sum - SW'(N_REQ);
            end
            idx = sum[IW-1:0];
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit seven-segment display between N_REQ clients, round-robin with a minimum hold.
// Grant appears two edges after a request in IDLE; display_data follows the granted word combinationally.
// Clients wait while another holds; the holder keeps the display until it drops req or its hold expires with others waiting.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int          N_REQ      = 4,
    parameter int          CLK_PER_MS = 100000,
    parameter int          HOLD_MS    = 1000,
    parameter logic [15:0] IDLE_CODE  = DEF_IDLE_CODE
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*16-1:0]      data_in,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] active_id,
    output logic                     busy,
    output logic [15:0]              display_data
);

    localparam int IW = $clog2(N_REQ);
    // A 1-cycle millisecond still needs a 1-bit prescaler register
    localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam int HW = $clog2(HOLD_MS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_MS);
    localparam logic [IW-1:0] PTR_INIT   = IW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE     = {{(N_REQ-1){1'b0}}, 1'b1};

    arb_state_t     state_q, state_nx;
    logic [N_REQ-1:0] grant_nx;
    logic [IW-1:0]  id_nx;
    logic [IW-1:0]  ptr_q, ptr_nx;
    logic [PW-1:0]  presc_q, presc_nx;
    logic [HW-1:0]  hold_q, hold_nx;

    logic [IW-1:0]  pick_id;
    logic           pick_found;
    logic           presc_wrap;
    logic           expired;
    logic           winner_req;
    logic           others_req;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_id),
        .found  (pick_found)
    );

    // Hold bookkeeping. Expiry is flagged one cycle early (on the last
    // prescaler tick of the final millisecond) so that the grant occupies
    // exactly HOLD_MS*CLK_PER_MS cycles before the hand-over edge.
    always_comb begin
        presc_wrap = (presc_q == PRESC_LAST);
        expired    = (hold_q == HOLD_MAX) ||
                     (presc_wrap && (hold_q == HOLD_MAX - 1'b1));
        winner_req = |(req & grant);
        others_req = |(req & ~grant);
    end

    // Next-state and next-register logic for the arbiter
    always_comb begin
        state_nx = state_q;
        grant_nx = grant;
        id_nx    = active_id;
        ptr_nx   = ptr_q;
        presc_nx = presc_q;
        hold_nx  = hold_q;

        case (state_q)
            IDLE: begin
                grant_nx = '0;
                id_nx    = '0;
                presc_nx = '0;
                hold_nx  = '0;
                if (|req) begin
                    state_nx = ARB;
                end
            end

            ARB: begin
                presc_nx = '0;
                hold_nx  = '0;
                if (pick_found) begin
                    state_nx = HOLD;
                    grant_nx = ONE << pick_id;
                    id_nx    = pick_id;
                    ptr_nx   = pick_id;
                end else begin
                    // Request vanished before we could pick: nothing to show
                    state_nx = IDLE;
                    grant_nx = '0;
                    id_nx    = '0;
                end
            end

            HOLD: begin
                // Winner-drop takes precedence over expiry; both lead to ARB
                if (!winner_req || (expired && others_req)) begin
                    state_nx = ARB;
                    grant_nx = '0;
                    id_nx    = '0;
                end else if (presc_wrap) begin
                    presc_nx = '0;
                    hold_nx  = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
                end else begin
                    presc_nx = presc_q + 1'b1;
                end
            end

            default: begin
                state_nx = IDLE;
                grant_nx = '0;
                id_nx    = '0;
                presc_nx = '0;
                hold_nx  = '0;
            end
        endcase
    end

    // Arbiter registers; clear returns everything to the idle picture at once
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q   <= IDLE;
            grant     <= '0;
            active_id <= '0;
            ptr_q     <= PTR_INIT;
            presc_q   <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_nx;
            grant     <= grant_nx;
            active_id <= id_nx;
            ptr_q     <= ptr_nx;
            presc_q   <= presc_nx;
            hold_q    <= hold_nx;
        end
    end

    // Display word: AND-OR select on the one-hot grant so live client
    // updates pass straight through; blank digits when nobody holds it
    always_comb begin
        display_data = IDLE_CODE;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                display_data = data_in[i*16 +: 16];
            end
        end
    end

    assign busy = |grant;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with short timing (10 cycles/ms, 3 ms hold).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each scenario task carries its own inline comparisons.
module tb_seg_display_arbiter;

    localparam int N_REQ    = 4;
    localparam int CPM      = 10;
    localparam int HMS      = 3;
    localparam int HOLD_CYC = CPM * HMS;

    logic        clk = 1'b0;
    logic        clear;
    logic [3:0]  req;
    logic [63:0] data_in;
    logic [3:0]  grant;
    logic [1:0]  active_id;
    logic        busy;
    logic [15:0] display_data;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seg_display_arbiter #(
        .N_REQ      (N_REQ),
        .CLK_PER_MS (CPM),
        .HOLD_MS    (HMS),
        .IDLE_CODE  (16'hBBBB)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .req          (req),
        .data_in      (data_in),
        .grant        (grant),
        .active_id    (active_id),
        .busy         (busy),
        .display_data (display_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        req = 4'b0000;
        repeat (3) step();
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant == 4'b0000 && n < 10) begin
            step();
            n++;
        end
    endtask

    function automatic logic [15:0] word_of(input int i);
        return data_in[i*16 +: 16];
    endfunction

    task automatic test_reset();
        clear   = 1'b1;
        req     = 4'b0000;
        data_in = {16'h0E01, 16'h89AB, 16'h4567, 16'h0123};
        repeat (2) step();
        checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want %b", grant, 4'b0000); else passed++;
        checks++; if (active_id !== 2'd0) $display("FAIL reset_active_id: got %0d want 0", active_id); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        checks++; if (display_data !== 16'hBBBB) $display("FAIL reset_display: got %h want bbbb", display_data); else passed++;
        clear = 1'b0;
        repeat (2) step();
        checks++; if (grant !== 4'b0000) $display("FAIL idle_no_req_grant: got %b want 0000", grant); else passed++;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [5];
        int         exp_id [5];
        int         n;
        int         cnt;
        exp_g  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_id = '{0, 1, 2, 3, 0};
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(n);
            checks++; if (grant !== exp_g[k]) $display("FAIL rr_grant%0d: got %b want %b", k, grant, exp_g[k]); else passed++;
            checks++; if (display_data !== word_of(exp_id[k])) $display("FAIL rr_display%0d: got %h want %h", k, display_data, word_of(exp_id[k])); else passed++;
            if (k < 4) begin
                cnt = 0;
                while (grant == exp_g[k] && cnt < 100) begin
                    step();
                    cnt++;
                end
                checks++; if (cnt !== HOLD_CYC) $display("FAIL rr_hold%0d: got %0d cycles want %0d", k, cnt, HOLD_CYC); else passed++;
            end
        end
        go_idle();
    endtask

    task automatic test_single_latency();
        data_in[15:0] = 16'h0123;
        req = 4'b0001;
        step();
        checks++; if (grant !== 4'b0000) $display("FAIL lat_arb_grant: got %b want 0000", grant); else passed++;
        step();
        checks++; if (grant !== 4'b0001) $display("FAIL lat_grant: got %b want 0001", grant); else passed++;
        checks++; if (display_data !== 16'h0123) $display("FAIL lat_display: got %h want 0123", display_data); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL lat_busy: got %b want 1", busy); else passed++;
        checks++; if (active_id !== 2'd0) $display("FAIL lat_active_id: got %0d want 0", active_id); else passed++;
        repeat (40) step();
        checks++; if (grant !== 4'b0001) $display("FAIL alone_held_grant: got %b want 0001", grant); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL alone_held_busy: got %b want 1", busy); else passed++;
    endtask

    task automatic test_live_passthrough();
        data_in[15:0] = 16'h0001;
        #1;
        checks++; if (display_data !== 16'h0001) $display("FAIL live_0001: got %h want 0001", display_data); else passed++;
        data_in[15:0] = 16'h0002;
        #1;
        checks++; if (display_data !== 16'h0002) $display("FAIL live_0002: got %h want 0002", display_data); else passed++;
        data_in[47:32] = 16'h7777;
        #1;
        checks++; if (display_data !== 16'h0002) $display("FAIL live_nonwinner: got %h want 0002", display_data); else passed++;
        data_in[47:32] = 16'h89AB;
        go_idle();
    endtask

    task automatic test_hold_time();
        int n;
        int cnt;
        req = 4'b0001;
        wait_grant(n);
        checks++; if (grant !== 4'b0001) $display("FAIL hold_first_grant: got %b want 0001", grant); else passed++;
        cnt = 0;
        while (grant == 4'b0001 && cnt < 100) begin
            if (cnt == 2) req[2] = 1'b1;
            step();
            cnt++;
        end
        checks++; if (cnt !== HOLD_CYC) $display("FAIL hold_cycles: got %0d want %0d", cnt, HOLD_CYC); else passed++;
        checks++; if (grant !== 4'b0000) $display("FAIL hold_arb_grant: got %b want 0000", grant); else passed++;
        checks++; if (display_data !== 16'hBBBB) $display("FAIL hold_arb_display: got %h want bbbb", display_data); else passed++;
        step();
        checks++; if (grant !== 4'b0100) $display("FAIL hold_next_grant: got %b want 0100", grant); else passed++;
        checks++; if (display_data !== 16'h89AB) $display("FAIL hold_next_display: got %h want 89ab", display_data); else passed++;
        checks++; if (active_id !== 2'd2) $display("FAIL hold_next_id: got %0d want 2", active_id); else passed++;
        go_idle();
    endtask

    task automatic test_early_release();
        int n;
        req = 4'b0010;
        wait_grant(n);
        checks++; if (grant !== 4'b0010) $display("FAIL early_grant: got %b want 0010", grant); else passed++;
        repeat (11) step();
        checks++; if (grant !== 4'b0010) $display("FAIL early_c12_grant: got %b want 0010", grant); else passed++;
        req = 4'b0000;
        step();
        checks++; if (grant !== 4'b0000) $display("FAIL early_drop_grant: got %b want 0000", grant); else passed++;
        checks++; if (display_data !== 16'hBBBB) $display("FAIL early_drop_display: got %h want bbbb", display_data); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL early_drop_busy: got %b want 0", busy); else passed++;
        step();
        checks++; if (grant !== 4'b0000) $display("FAIL early_idle_grant: got %b want 0000", grant); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL early_idle_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_async_reset();
        int n;
        req = 4'b1111;
        wait_grant(n);
        checks++; if (grant !== 4'b0100) $display("FAIL async_pre_grant: got %b want 0100", grant); else passed++;
        repeat (5) step();
        #3;
        clear = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000) $display("FAIL async_grant: got %b want 0000", grant); else passed++;
        checks++; if (display_data !== 16'hBBBB) $display("FAIL async_display: got %h want bbbb", display_data); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL async_busy: got %b want 0", busy); else passed++;
        checks++; if (active_id !== 2'd0) $display("FAIL async_active_id: got %0d want 0", active_id); else passed++;
        #1;
        clear = 1'b0;
        wait_grant(n);
        checks++; if (n !== 2) $display("FAIL async_relatency: got %0d edges want 2", n); else passed++;
        checks++; if (grant !== 4'b0001) $display("FAIL async_first_winner: got %b want 0001", grant); else passed++;
        checks++; if (display_data !== 16'h0002) $display("FAIL async_first_display: got %h want 0002", display_data); else passed++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_latency();
        test_live_passthrough();
        test_hold_time();
        test_early_release();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
